// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: the 32-bit word type, the fetch-stage states and the bubble word.
// Also provides the helper that word-aligns a redirect target.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // sll $0,$0,0
  localparam word_t NOP_INSTR = 32'h0000_0000;

  function automatic word_t align_word(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer for the fetch stage.
// Keeps an instruction word and its PC+4 while IF/ID is stalled.
module fetch_skid_buf
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  capture,
  input  logic  drop,
  input  word_t word_in,
  input  word_t pc_4_in,
  output word_t word_out,
  output word_t pc_4_held,
  output logic  valid
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      word_out  <= '0;
      pc_4_held <= '0;
      valid     <= 1'b0;
    end else if (capture) begin
      word_out  <= word_in;
      pc_4_held <= pc_4_in;
      valid     <= 1'b1;
    end else if (drop) begin
      valid     <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues imem reads, applies stall/redirect/halt.
// Build with FETCH_SKID_EN to keep a stalled fetch in a one-entry skid buffer instead of refetching.
//
// state  | meaning
// FETCH  | reading imem at PC, emitting the returned word when IF/ID accepts it
// HOLD   | imem idle, emitting the word held in the skid buffer (FETCH_SKID_EN only)
// HALTED | halt committed; no reads, bubbles only, left only through RST
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT   = 32'h0000_0000,
  parameter word_t NOP_INSTR = cpu_types_pkg::NOP_INSTR
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  ihit,
  input  word_t iload,
  output logic  imemREN,
  output word_t imemaddr,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_addr,
  input  logic  halt,
  output word_t instr_out,
  output word_t pc_4_out,
  output logic  instr_valid
);

  fetch_state_t state;
  word_t        pc;
  word_t        pc_4;
  word_t        hold_word;
  word_t        hold_pc_4;
  logic         hold_valid;
  logic         squash;

  assign pc_4   = pc + 32'd4;
  assign squash = halt | redirect;

`ifdef FETCH_SKID_EN
  logic hold_capture;
  logic hold_drop;

  assign hold_capture = (state == FETCH) && ihit && stall && !squash;
  assign hold_drop    = (state == HOLD) && (squash || !stall);

  fetch_skid_buf u_skid (
    .CLK       (CLK),
    .RST       (RST),
    .capture   (hold_capture),
    .drop      (hold_drop),
    .word_in   (iload),
    .pc_4_in   (pc_4),
    .word_out  (hold_word),
    .pc_4_held (hold_pc_4),
    .valid     (hold_valid)
  );
`else
  assign hold_word  = NOP_INSTR;
  assign hold_pc_4  = '0;
  assign hold_valid = 1'b0;
`endif

  always_comb begin
    imemaddr    = pc;
    imemREN     = 1'b0;
    instr_out   = NOP_INSTR;
    pc_4_out    = pc_4;
    instr_valid = 1'b0;
    case (state)
      FETCH: begin
        imemREN = 1'b1;
        if (ihit && !stall && !squash) begin
          instr_out   = iload;
          instr_valid = 1'b1;
        end
      end
      HOLD: begin
        pc_4_out = hold_pc_4;
        if (!squash) begin
          instr_out   = hold_word;
          instr_valid = hold_valid && !stall;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc    <= PC_INIT;
      state <= FETCH;
    end else if (state != HALTED) begin
      if (halt) begin
        state <= HALTED;
      end else if (redirect) begin
        pc    <= align_word(redirect_addr);
        state <= FETCH;
      end else if (state == FETCH) begin
        if (ihit && !stall) begin
          pc <= pc_4;
        end
`ifdef FETCH_SKID_EN
        else if (ihit && stall) begin
          pc    <= pc_4;
          state <= HOLD;
        end
`endif
      end else if (!stall) begin
        state <= FETCH;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, imem misses, redirect, stall, PC wrap, halt and reset.
// Expected values are hand-computed constants; works for both FETCH_SKID_EN builds.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST;
  logic  ihit;
  word_t iload;
  logic  imemREN;
  word_t imemaddr;
  logic  stall;
  logic  redirect;
  word_t redirect_addr;
  logic  halt;
  word_t instr_out;
  word_t pc_4_out;
  logic  instr_valid;

  int nvec = 0;
  int nerr = 0;

  fetch_unit dut (
    .CLK           (CLK),
    .RST           (RST),
    .ihit          (ihit),
    .iload         (iload),
    .imemREN       (imemREN),
    .imemaddr      (imemaddr),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halt          (halt),
    .instr_out     (instr_out),
    .pc_4_out      (pc_4_out),
    .instr_valid   (instr_valid)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one clock edge, then let combinational outputs settle away from the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; iload = 32'h0; stall = 1'b0;
    redirect = 1'b0; redirect_addr = 32'h0; halt = 1'b0;
    #2;
    tick();
    RST = 1'b0;
    #1;
    chk("reset_addr", imemaddr, 32'h0);
    chk("reset_ren", {31'b0, imemREN}, 32'd1);
    chk("reset_valid_noihit", {31'b0, instr_valid}, 32'd0);

    // sequential fetch with ihit every cycle
    ihit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iload = 32'h1000_0000 + i;
      #1;
      chk("seq_addr", imemaddr, 32'(4 * i));
      chk("seq_pc4", pc_4_out, 32'(4 * i + 4));
      chk("seq_valid", {31'b0, instr_valid}, 32'd1);
      chk("seq_instr", instr_out, 32'h1000_0000 + i);
      tick();
    end

    // three imem misses at PC=16
    ihit = 1'b0; iload = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("miss_addr", imemaddr, 32'h10);
      chk("miss_valid", {31'b0, instr_valid}, 32'd0);
      chk("miss_instr", instr_out, 32'h0);
      chk("miss_pc4", pc_4_out, 32'h14);
      tick();
    end
    ihit = 1'b1; iload = 32'h2222_0000;
    #1;
    chk("resume_addr", imemaddr, 32'h10);
    chk("resume_valid", {31'b0, instr_valid}, 32'd1);
    tick();
    chk("resume_next", imemaddr, 32'h14);

    // redirect with unaligned target while ihit
    redirect = 1'b1; redirect_addr = 32'h0000_0103;
    #1;
    chk("redir_bubble", {31'b0, instr_valid}, 32'd0);
    chk("redir_instr", instr_out, 32'h0);
    tick();
    redirect = 1'b0;
    #1;
    chk("redir_target", imemaddr, 32'h100);

    // stall for two cycles with ihit at 0x20
    redirect = 1'b1; redirect_addr = 32'h20;
    tick();
    redirect = 1'b0; stall = 1'b1; iload = 32'hABCD_0020;
    #1;
    chk("stall0_addr", imemaddr, 32'h20);
    chk("stall0_ren", {31'b0, imemREN}, 32'd1);
    chk("stall0_valid", {31'b0, instr_valid}, 32'd0);
    tick();
`ifdef FETCH_SKID_EN
    iload = 32'h5555_5555;
    #1;
    chk("hold_ren", {31'b0, imemREN}, 32'd0);
    chk("hold_valid_stalled", {31'b0, instr_valid}, 32'd0);
    tick();
    stall = 1'b0;
    #1;
    chk("hold_emit_valid", {31'b0, instr_valid}, 32'd1);
    chk("hold_emit_instr", instr_out, 32'hABCD_0020);
    chk("hold_emit_pc4", pc_4_out, 32'h24);
    chk("hold_emit_ren", {31'b0, imemREN}, 32'd0);
    tick();
    iload = 32'h3333_0024;
    #1;
    chk("after_hold_addr", imemaddr, 32'h24);
    chk("after_hold_ren", {31'b0, imemREN}, 32'd1);
`else
    #1;
    chk("stall1_addr", imemaddr, 32'h20);
    chk("stall1_ren", {31'b0, imemREN}, 32'd1);
    tick();
    stall = 1'b0;
    #1;
    chk("unstall_addr", imemaddr, 32'h20);
    chk("unstall_valid", {31'b0, instr_valid}, 32'd1);
    chk("unstall_instr", instr_out, 32'hABCD_0020);
    chk("unstall_pc4", pc_4_out, 32'h24);
    tick();
    chk("after_stall_addr", imemaddr, 32'h24);
`endif

    // PC wrap at the top of the address space
    redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0; iload = 32'h7777_0000;
    #1;
    chk("wrap_addr", imemaddr, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_4_out, 32'h0);
    tick();
    chk("wrap_next", imemaddr, 32'h0);
    tick();
    chk("pre_halt_addr", imemaddr, 32'h4);

    // halt and redirect together: halt wins
    halt = 1'b1; redirect = 1'b1; redirect_addr = 32'h200;
    #1;
    chk("halt_bubble", {31'b0, instr_valid}, 32'd0);
    tick();
    halt = 1'b0; redirect = 1'b0;
    #1;
    chk("halted_ren", {31'b0, imemREN}, 32'd0);
    chk("halted_addr", imemaddr, 32'h4);
    chk("halted_valid", {31'b0, instr_valid}, 32'd0);
    redirect = 1'b1; redirect_addr = 32'h300;
    tick();
    redirect = 1'b0;
    tick();
    chk("halted_frozen", imemaddr, 32'h4);
    chk("halted_ren2", {31'b0, imemREN}, 32'd0);

    // reset leaves HALTED even with halt/redirect asserted
    RST = 1'b1; halt = 1'b1; redirect = 1'b1; redirect_addr = 32'h400;
    tick();
    RST = 1'b0; halt = 1'b0; redirect = 1'b0;
    #1;
    chk("rst_addr", imemaddr, 32'h0);
    chk("rst_ren", {31'b0, imemREN}, 32'd1);
    chk("rst_valid", {31'b0, instr_valid}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
